// File: rtl/fc_input_packer.sv
// fc_input_packer: reorders position-major pooled values into FC1's channel-major A/B banks
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   en             level enable, low aborts to IDLE
//   start          one-cycle pack request, accepted only in IDLE with en high
//   pool_read_addr pool buffer address p*CHANNELS + c
//   pool_read_data pool buffer data, one-cycle read latency
//   bank_a_we      bank A write enable (j < HALF_SET)
//   bank_b_we      bank B write enable (j >= HALF_SET)
//   bank_wr_addr   shared bank address g*HALF_SET + j%HALF_SET
//   bank_wr_data   shared bank write data
//   busy           high from start acceptance until done
//   pack_done      one-cycle completion pulse
// Optional: define FC_PACK_RELU_EN to clamp negative values to zero on the write path.
module fc_input_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 16,
    parameter int POSITIONS  = 25,
    parameter int HALF_SET   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    output logic [8:0]                   pool_read_addr,
    input  logic signed [DATA_WIDTH-1:0] pool_read_data,
    output logic                         bank_a_we,
    output logic                         bank_b_we,
    output logic [7:0]                   bank_wr_addr,
    output logic [DATA_WIDTH-1:0]        bank_wr_data,
    output logic                         busy,
    output logic                         pack_done
);
    localparam int CW = $clog2(CHANNELS);
    localparam int PW = $clog2(POSITIONS);
    localparam logic [CW-1:0] LAST_C = CW'(CHANNELS - 1);
    localparam logic [PW-1:0] LAST_P = PW'(POSITIONS - 1);
    localparam logic [8:0] GRP = 9'(2 * HALF_SET);
    localparam logic [8:0] HS  = 9'(HALF_SET);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state, nxt;
    logic [CW-1:0]   c;
    logic [PW-1:0]   p;
    logic [8:0]      n;
    logic            rd, last, hi;
    logic [DATA_WIDTH-1:0] wr_val;

    assign rd   = en && state == READ;
    assign last = c == LAST_C && p == LAST_P;
    assign hi   = (n % GRP) >= HS;

    always_comb begin
        nxt            = state;
        busy           = state != IDLE;
        pack_done      = state == DONE;
        pool_read_addr = state == READ ? 9'(p * CHANNELS + c) : '0;
        if (!en)
            nxt = IDLE;
        else if (state == IDLE && start)
            nxt = READ;
        else if (state == READ && last)
            nxt = DRAIN;
        else if (state == DRAIN)
            nxt = DONE;
        else if (state == DONE)
            nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Write strobes and address trail the read by one cycle, lining up with the pool data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c            <= '0;
            p            <= '0;
            n            <= '0;
            bank_a_we    <= 1'b0;
            bank_b_we    <= 1'b0;
            bank_wr_addr <= '0;
        end else begin
            bank_a_we    <= rd && !hi;
            bank_b_we    <= rd && hi;
            bank_wr_addr <= rd ? 8'(n / GRP * HS + n % HS) : '0;
            n            <= rd ? n + 1'b1 : '0;
            p            <= rd && p != LAST_P ? p + 1'b1 : '0;
            c            <= !rd ? '0 : p == LAST_P ? c + 1'b1 : c;
        end
    end

`ifdef FC_PACK_RELU_EN
    assign wr_val = pool_read_data < 0 ? '0 : pool_read_data;
`else
    assign wr_val = pool_read_data;
`endif

    // Data is gated by the strobes so the bus reads zero whenever nothing is written.
    assign bank_wr_data = bank_a_we || bank_b_we ? wr_val : '0;
endmodule
